// File: rtl/sparc_pkg.sv
// Shared encodings for the SPARC-subset front end: instruction fields, ALU opcodes,
// data-memory sizes and the bit layout of the 19-bit control word.
package sparc_pkg;

    localparam int CTRL_W = 19;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_CALL  = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM   = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_SLL  = 6'b100101;
    localparam logic [5:0] OP3_SRL  = 6'b100110;
    localparam logic [5:0] OP3_SRA  = 6'b100111;
    localparam logic [5:0] OP3_JMPL = 6'b111000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b1010;
    localparam logic [3:0] ALU_SRL   = 4'b1011;
    localparam logic [3:0] ALU_SRA   = 4'b1101;
    localparam logic [3:0] ALU_PASSB = 4'b1110;

    localparam logic [1:0] DM_BYTE   = 2'b00;
    localparam logic [1:0] DM_HALF   = 2'b01;
    localparam logic [1:0] DM_WORD   = 2'b10;
    localparam logic [1:0] DM_DOUBLE = 2'b11;

    localparam logic [1:0] SEL_NPC  = 2'b00;
    localparam logic [1:0] SEL_TA   = 2'b01;
    localparam logic [1:0] SEL_ALU  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    localparam int SIG_JMPL    = 0;
    localparam int SIG_CALL    = 1;
    localparam int SIG_LOAD    = 2;
    localparam int SIG_RF_WE   = 3;
    localparam int SIG_DM_SE   = 4;
    localparam int SIG_DM_RW   = 5;
    localparam int SIG_DM_EN   = 6;
    localparam int SIG_DM_SZ_L = 7;
    localparam int SIG_DM_SZ_H = 8;
    localparam int SIG_CC_EN   = 9;
    localparam int SIG_I31     = 10;
    localparam int SIG_I30     = 11;
    localparam int SIG_I24     = 12;
    localparam int SIG_I13     = 13;
    localparam int SIG_ALU_L   = 14;
    localparam int SIG_ALU_H   = 17;
    localparam int SIG_BRANCH  = 18;

    // ld/st op3[1:0] order is word, byte, half, double
    function automatic logic [1:0] dm_size(input logic [1:0] op3_lo);
        logic [1:0] sz;
        case (op3_lo)
            2'b00:   sz = DM_WORD;
            2'b01:   sz = DM_BYTE;
            2'b10:   sz = DM_HALF;
            2'b11:   sz = DM_DOUBLE;
            default: sz = DM_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/sparc_ctrl_decode.sv
// Combinational decoder: IF/ID instruction word to the 19-bit control word.
module sparc_ctrl_decode
    import sparc_pkg::*;
(
    input  logic [31:0]       instr,
    output logic [CTRL_W-1:0] instr_signals
);

    logic [1:0] w_op;
    logic [2:0] w_op2;
    logic [5:0] w_op3;
    logic       w_unused;

    assign w_op     = instr[31:30];
    assign w_op2    = instr[24:22];
    assign w_op3    = instr[24:19];
    assign w_unused = ^{instr[29:25], instr[18:14], instr[12:0]};

    // Field-by-field decode; unrecognised format-2 words keep only the raw bits
    always_comb begin
        instr_signals              = 19'd0;
        instr_signals[SIG_I31]     = instr[31];
        instr_signals[SIG_I30]     = instr[30];
        instr_signals[SIG_I24]     = instr[24];
        instr_signals[SIG_I13]     = instr[13];
        case (w_op)
            OP_FMT2: begin
                case (w_op2)
                    OP2_BICC: instr_signals[SIG_BRANCH] = 1'b1;
                    OP2_SETHI: begin
                        instr_signals[SIG_RF_WE]             = 1'b1;
                        instr_signals[SIG_ALU_H:SIG_ALU_L]   = ALU_PASSB;
                    end
                    default: instr_signals[SIG_BRANCH] = 1'b0;
                endcase
            end
            OP_CALL: begin
                instr_signals[SIG_CALL]  = 1'b1;
                instr_signals[SIG_RF_WE] = 1'b1;
            end
            OP_ARITH: begin
                instr_signals[SIG_RF_WE] = 1'b1;
                if (w_op3[5] == 1'b0) begin
                    instr_signals[SIG_ALU_H:SIG_ALU_L] = w_op3[3:0];
                    instr_signals[SIG_CC_EN]           = w_op3[4];
                end else begin
                    case (w_op3)
                        OP3_SLL:  instr_signals[SIG_ALU_H:SIG_ALU_L] = ALU_SLL;
                        OP3_SRL:  instr_signals[SIG_ALU_H:SIG_ALU_L] = ALU_SRL;
                        OP3_SRA:  instr_signals[SIG_ALU_H:SIG_ALU_L] = ALU_SRA;
                        OP3_JMPL: instr_signals[SIG_JMPL]            = 1'b1;
                        default:  instr_signals[SIG_ALU_H:SIG_ALU_L] = ALU_ADD;
                    endcase
                end
            end
            OP_MEM: begin
                instr_signals[SIG_DM_EN]               = 1'b1;
                instr_signals[SIG_DM_SZ_H:SIG_DM_SZ_L] = dm_size(w_op3[1:0]);
                if (w_op3[2]) begin
                    instr_signals[SIG_DM_RW] = 1'b1;
                end else begin
                    instr_signals[SIG_LOAD]  = 1'b1;
                    instr_signals[SIG_RF_WE] = 1'b1;
                    instr_signals[SIG_DM_SE] = w_op3[3];
                end
            end
            default: instr_signals[SIG_DM_EN] = 1'b0;
        endcase
    end

endmodule

// File: rtl/sparc_fetch_decode_ctrl.sv
// PC register with +4 incrementer and four-way next-PC select, plus the control decoder.
module sparc_fetch_decode_ctrl
    import sparc_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              LE,
    input  logic [1:0]        mux_select,
    input  logic [31:0]       TA,
    input  logic [31:0]       ALU_OUT,
    input  logic [31:0]       instr,
    output logic [31:0]       PC,
    output logic [31:0]       nPC,
    output logic [CTRL_W-1:0] instr_signals
);

    logic [31:0] r_pc;
    logic [31:0] w_npc;
    logic [31:0] w_pc_next;

    assign w_npc = r_pc + 32'd4;

    // Next-PC source mux
    always_comb begin
        w_pc_next = w_npc;
        case (mux_select)
            SEL_NPC:  w_pc_next = w_npc;
            SEL_TA:   w_pc_next = TA;
            SEL_ALU:  w_pc_next = ALU_OUT;
            SEL_HOLD: w_pc_next = r_pc;
            default:  w_pc_next = r_pc;
        endcase
    end

    // PC register: clear wins over hold, hold wins over load
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pc <= 32'd0;
        end else if (LE) begin
            r_pc <= w_pc_next;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign PC  = r_pc;
    assign nPC = w_npc;

    sparc_ctrl_decode u_decode (
        .instr         (instr),
        .instr_signals (instr_signals)
    );

endmodule

// File: tb/tb_sparc_fetch_decode_ctrl.sv
// Bench for sparc_fetch_decode_ctrl: directed scenarios, then random cycles against a reference model.
module tb_sparc_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        LE;
    logic [1:0]  mux_select;
    logic [31:0] TA;
    logic [31:0] ALU_OUT;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] nPC;
    logic [18:0] instr_signals;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] m_pc  = 32'd0;

    always #5 clk = ~clk;

    sparc_fetch_decode_ctrl dut (
        .clk           (clk),
        .clr           (clr),
        .LE            (LE),
        .mux_select    (mux_select),
        .TA            (TA),
        .ALU_OUT       (ALU_OUT),
        .instr         (instr),
        .PC            (PC),
        .nPC           (nPC),
        .instr_signals (instr_signals)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference decoder written from the instruction-class rules
    function automatic logic [18:0] ref_decode(input logic [31:0] w);
        int          op, op2, op3, alu, sz;
        int          sz_tab [4] = '{2, 0, 1, 3};
        bit          is_call, is_sethi, is_br, is_arith, is_mem, is_load, is_store;
        logic [18:0] s;
        op  = w[31:30];
        op2 = w[24:22];
        op3 = w[24:19];
        is_call  = (op == 1);
        is_sethi = (op == 0) && (op2 == 4);
        is_br    = (op == 0) && (op2 == 2);
        is_arith = (op == 2);
        is_mem   = (op == 3);
        is_load  = is_mem && ((op3 / 4) % 2 == 0);
        is_store = is_mem && !is_load;
        if (is_arith && op3 < 32)       alu = op3 % 16;
        else if (is_arith && op3 == 37) alu = 10;
        else if (is_arith && op3 == 38) alu = 11;
        else if (is_arith && op3 == 39) alu = 13;
        else if (is_sethi)              alu = 14;
        else                            alu = 0;
        sz = is_mem ? sz_tab[op3 % 4] : 0;
        s = 19'd0;
        s[0]  = is_arith && (op3 == 56);
        s[1]  = is_call;
        s[2]  = is_load;
        s[3]  = is_call || is_sethi || is_arith || is_load;
        s[4]  = is_load && ((op3 / 8) % 2 == 1);
        s[5]  = is_store;
        s[6]  = is_mem;
        s[8:7] = 2'(sz);
        s[9]  = is_arith && (op3 >= 16) && (op3 < 32);
        s[10] = w[31];
        s[11] = w[30];
        s[12] = w[24];
        s[13] = w[13];
        s[17:14] = 4'(alu);
        s[18] = is_br;
        return s;
    endfunction

    // One clock edge; the model follows the next-PC rules on the inputs present at the edge
    task automatic tick;
        logic [31:0] src [4];
        src[0] = m_pc + 32'd4;
        src[1] = TA;
        src[2] = ALU_OUT;
        src[3] = m_pc;
        if (clr)     m_pc = 32'd0;
        else if (LE) m_pc = src[mux_select];
        @(posedge clk);
        #1;
    endtask

    task automatic check_dec(input string tag, input logic [31:0] w, input logic [31:0] exp);
        instr = w;
        #1;
        check_eq(tag, {13'd0, instr_signals}, exp);
    endtask

    logic [5:0] op3_pick [6] = '{6'h25, 6'h26, 6'h27, 6'h38, 6'h10, 6'h14};

    initial begin
        clr = 1'b1; LE = 1'b0; mux_select = 2'b00;
        TA = 32'd0; ALU_OUT = 32'd0; instr = 32'd0;
        @(negedge clk);
        tick();
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_npc", nPC, 32'h4);

        clr = 1'b0; LE = 1'b1; mux_select = 2'b00;
        repeat (3) tick();
        check_eq("run_pc", PC, 32'd12);
        check_eq("run_npc", nPC, 32'd16);

        LE = 1'b0;
        repeat (2) tick();
        check_eq("hold_le", PC, 32'd12);
        LE = 1'b1; mux_select = 2'b11;
        tick();
        check_eq("hold_sel", PC, 32'd12);

        mux_select = 2'b01; TA = 32'h40;
        tick();
        check_eq("ta_pc", PC, 32'h40);
        mux_select = 2'b10; ALU_OUT = 32'h80;
        tick();
        check_eq("alu_pc", PC, 32'h80);
        mux_select = 2'b01; TA = 32'hFFFF_FFFC;
        tick();
        check_eq("wrap_pc", PC, 32'hFFFF_FFFC);
        check_eq("wrap_npc", nPC, 32'h0);
        mux_select = 2'b00;
        tick();
        check_eq("wrap_step", PC, 32'h0);

        check_dec("dec_add", 32'h8600_4002, 32'h0_0408);
        check_dec("dec_ldub", 32'hC408_6004, 32'h0_2C4C);
        check_dec("dec_ba", 32'h1080_0004, 32'h4_0000);
        check_dec("dec_call", 32'h4000_0010, 32'h0_080A);
        check_dec("dec_zero", 32'h0000_0000, 32'h0);
        check_dec("dec_sethi", 32'h0300_0000, 32'h3_9008);

        clr = 1'b1; LE = 1'b1; mux_select = 2'b01; TA = 32'h40;
        tick();
        check_eq("clr_prio", PC, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            clr        = ($urandom_range(0, 15) == 0);
            LE         = ($urandom_range(0, 3) != 0);
            mux_select = 2'($urandom_range(0, 3));
            TA         = $urandom;
            ALU_OUT    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            w          = $urandom;
            if ($urandom_range(0, 3) == 0) w[24:19] = op3_pick[$urandom_range(0, 5)];
            instr      = w;
            tick();
            check_eq("rnd_pc", PC, m_pc);
            check_eq("rnd_npc", nPC, m_pc + 32'd4);
            check_eq("rnd_dec", {13'd0, instr_signals}, {13'd0, ref_decode(instr)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
